// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared mode and direction encodings for the LED pattern generator
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'd0,
    MODE_ROT_R  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// rtl/led_pattern_gen_tick_gen.sv - free-running step divider with pause hold and synchronous clear
module tick_gen #(
  parameter int TICK_PERIOD = 25000000,
  parameter int CNT_W       = $clog2(TICK_PERIOD)
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic pause,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // clr outranks pause so a load always restarts a full period
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!pause) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_MAX) && !pause && !clr;

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - LED pattern generator: mode/dir/led registers stepped by tick_gen
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int LED_NUM     = 4,
  parameter int TICK_PERIOD = 25000000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [1:0]         mode_sel,
  input  logic               mode_load,
  input  logic               pause,
  output logic [LED_NUM-1:0] led,
  output logic               tick
);

  localparam int CNT_W = $clog2(TICK_PERIOD);
  localparam logic [LED_NUM-1:0] LED_FIRST = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] LED_LAST  = LED_FIRST << (LED_NUM - 1);

  mode_t              mode, mode_nxt;
  dir_t               dir, dir_nxt;
  logic [LED_NUM-1:0] led_nxt;

  // Written as shift-or so a single LED simply holds its value
  function automatic logic [LED_NUM-1:0] rot_l(input logic [LED_NUM-1:0] v);
    return (v << 1) | (v >> (LED_NUM - 1));
  endfunction

  function automatic logic [LED_NUM-1:0] rot_r(input logic [LED_NUM-1:0] v);
    return (v >> 1) | (v << (LED_NUM - 1));
  endfunction

  tick_gen #(
    .TICK_PERIOD(TICK_PERIOD),
    .CNT_W      (CNT_W)
  ) u_tick_gen (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .pause  (pause),
    .clr    (mode_load),
    .tick   (tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      mode <= MODE_ROT_L;
      dir  <= DIR_UP;
      led  <= LED_FIRST;
    end else begin
      mode <= mode_nxt;
      dir  <= dir_nxt;
      led  <= led_nxt;
    end
  end

  always_comb begin
    mode_nxt = mode;
    dir_nxt  = dir;
    led_nxt  = led;
    if (mode_load) begin
      mode_nxt = mode_t'(mode_sel);
      case (mode_t'(mode_sel))
        MODE_ROT_L, MODE_BOUNCE: begin
          led_nxt = LED_FIRST;
          dir_nxt = DIR_UP;
        end
        MODE_ROT_R: led_nxt = LED_LAST;
        MODE_BLINK: led_nxt = '1;
      endcase
    end else if (tick) begin
      case (mode)
        MODE_ROT_L: led_nxt = rot_l(led);
        MODE_ROT_R: led_nxt = rot_r(led);
        // Turn around on the endpoint itself so it is never shown twice in a row
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            if (led[LED_NUM-1]) begin
              dir_nxt = DIR_DOWN;
              led_nxt = rot_r(led);
            end else begin
              led_nxt = rot_l(led);
            end
          end else begin
            if (led[0]) begin
              dir_nxt = DIR_UP;
              led_nxt = rot_l(led);
            end else begin
              led_nxt = rot_r(led);
            end
          end
        end
        MODE_BLINK: led_nxt = ~led;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - scoreboard bench for led_pattern_gen against a step-count reference model
module tb_led_pattern_gen;

  localparam int N = 4;
  localparam int P = 4;

  logic         sys_clk   = 1'b0;
  logic         sys_rst   = 1'b0;
  logic [1:0]   mode_sel  = 2'd0;
  logic         mode_load = 1'b0;
  logic         pause     = 1'b0;
  logic [N-1:0] led;
  logic         tick;

  led_pattern_gen #(
    .LED_NUM    (N),
    .TICK_PERIOD(P)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .mode_sel (mode_sel),
    .mode_load(mode_load),
    .pause    (pause),
    .led      (led),
    .tick     (tick)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic         tick;
    logic [N-1:0] led;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  // Model state: active mode, steps taken since load/reset, unpaused cycles into the period
  int m_mode  = 0;
  int m_k     = 0;
  int m_phase = 0;

  function automatic logic [N-1:0] model_led(input int mode, input int k);
    logic [N-1:0] one;
    int p;
    int idx;
    one = 1;
    case (mode)
      0: return one << (k % N);
      1: return one << (N - 1 - (k % N));
      2: begin
        p   = k % (2 * N - 2);
        idx = (p < N) ? p : (2 * N - 2 - p);
        return one << idx;
      end
      default: return (k % 2 == 0) ? {N{1'b1}} : {N{1'b0}};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and push what the DUT should show during that cycle
  task automatic issue(input bit ld, input logic [1:0] sel, input bit ps);
    exp_t e;
    mode_load = ld;
    mode_sel  = sel;
    pause     = ps;
    e.tick = !ld && !ps && (m_phase == P - 1);
    e.led  = model_led(m_mode, m_k);
    sb.push_back(e);
    if (ld) begin
      m_mode  = int'(sel);
      m_k     = 0;
      m_phase = 0;
    end else if (!ps) begin
      if (m_phase == P - 1) begin
        m_phase = 0;
        m_k++;
      end else begin
        m_phase++;
      end
    end
  endtask

  task automatic run_plain(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      issue(1'b0, 2'd0, 1'b0);
      @(posedge sys_clk);
      #1;
    end
  endtask

  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got no expected entry at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tick", 32'(tick), 32'(e.tick));
        check("led", 32'(led), 32'(e.led));
      end
    end
  end

  initial begin
    logic ps;
    ps = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_led", 32'(led), 32'd1);
    check("reset_tick", 32'(tick), 32'd0);
    sys_rst = 1'b1;
    mon_en  = 1'b1;

    run_plain(20);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) ps = ~ps;
      issue($urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)), ps);
      @(posedge sys_clk);
      #1;
    end

    issue(1'b1, 2'd2, 1'b0);
    @(posedge sys_clk);
    #1;
    run_plain(22);

    mon_en = 1'b0;
    #2;
    sys_rst = 1'b0;
    #1;
    check("async_reset_led", 32'(led), 32'd1);
    check("async_reset_tick", 32'(tick), 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    m_mode  = 0;
    m_k     = 0;
    m_phase = 0;
    mon_en  = 1'b1;
    run_plain(24);
    mon_en = 1'b0;

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised LED pattern generator driving LED_NUM board LEDs.
- A free-running tick divider sets the step rate.
- Four run-time selectable patterns: rotate left, rotate right, bounce, blink-all.
- Sits between the board clock/reset and the LED pins. Top level drives `mode_sel` and `mode_load` from switches or a debounced key, and `pause` from a switch.

Parameters:
- LED_NUM, 4, number of LEDs driven. Legal range is 1 or more.
- TICK_PERIOD, 25000000, sys_clk cycles per pattern step. Legal range is 2 or more.
- CNT_W, $clog2(TICK_PERIOD), counter width. Localparam, derived, not overridable.

Ports:
- sys_clk  in  1  system clock (50 MHz board clock).
- sys_rst  in  1  asynchronous active-low reset.
- mode_sel  in  2  requested pattern. 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK.
- mode_load  in  1  single-cycle strobe that loads `mode_sel` and restarts the pattern.
- pause  in  1  level input. While high, the counter and pattern freeze.
- led  out  LED_NUM  LED drive, active high.
- tick  out  1  step strobe, high for exactly one cycle per step.

Behaviour:
- Clock, reset and registers:
  - Clock is sys_clk; reset is sys_rst, asynchronous, active-low.
  - All registers are async-cleared.
- Reset values:
  - cnt = 0, mode = ROT_L, dir = UP.
  - led = one-hot bit 0 (`{LED_NUM-1{0},1}`).
  - tick = 0.
- Counter:
  - `cnt` counts 0..TICK_PERIOD-1 and wraps to 0.
  - While pause = 1, cnt holds.
  - When mode_load = 1, cnt clears to 0 (see load rule).
- tick:
  - tick = (cnt == TICK_PERIOD-1) && !pause && !mode_load.
  - It is decoded combinationally from the `cnt` register.
  - The pattern advances on the same sys_clk edge that tick is high, so one step occurs every TICK_PERIOD unpaused cycles.
- Mode register and pattern FSM: ROT_L, ROT_R, BOUNCE, BLINK. Mode changes only on mode_load.
- Load rule (highest priority; acts even when pause = 1). On the edge with mode_load = 1:
  - mode <= mode_sel and cnt <= 0.
  - ROT_L and BOUNCE: led <= one-hot bit 0, dir <= UP.
  - ROT_R: led <= one-hot bit LED_NUM-1.
  - BLINK: led <= all ones.
  - Reloading the same mode restarts it.
- Step rules (on tick):
  - ROT_L: led <= {led[LED_NUM-2:0], led[LED_NUM-1]}.
  - ROT_R: led <= {led[0], led[LED_NUM-1:1]}.
  - BOUNCE, dir UP:
    - If led[LED_NUM-1] = 1: dir <= DOWN and shift right.
    - Otherwise: shift left.
  - BOUNCE, dir DOWN:
    - If led[0] = 1: dir <= UP and shift left.
    - Otherwise: shift right.
  - BOUNCE produces no repeated endpoint. For LED_NUM = 4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
  - BLINK: led <= ~led.
- Boundaries:
  - LED_NUM = 1: rotates and bounce hold led = 1; BLINK toggles.
  - LED_NUM = 2, ROT_L: 01, 10, 01, … (matches legacy two-LED flasher).
  - pause asserted mid-period: cnt freezes at its current value. On release, counting resumes from that value; there is no restart.
  - mode_load and tick in the same cycle: load wins and tick is suppressed.
  - Reset mid-pattern: all state returns to reset values immediately (asynchronous).
- Invariant: in ROT_L, ROT_R and BOUNCE, led is always one-hot. In BLINK, led is all-0 or all-1.

Decomposition:
- Package `led_pattern_pkg`:
  - Mode encodings MODE_ROT_L = 2'd0, MODE_ROT_R = 2'd1, MODE_BOUNCE = 2'd2, MODE_BLINK = 2'd3.
  - Direction encodings DIR_UP = 1'b0, DIR_DOWN = 1'b1.
- Sub-module `tick_gen`:
  - Parameters TICK_PERIOD and CNT_W.
  - Ports sys_clk, sys_rst, pause, clr, tick.
  - Contains the counter and the tick decode.
- `led_pattern_gen` instantiates tick_gen with clr = mode_load, and holds the mode/dir/led registers.

Test Plan (LED_NUM = 4, TICK_PERIOD = 4):
1. Reset release, mode_load never asserted → led = 0001 at reset. First tick at cycle 4; led then steps 0010, 0100, 1000, 0001, one step per tick. tick pulses every 4 cycles.
2. mode_sel = 1, pulse mode_load → led = 1000 on the next edge. Steps are 0100, 0010, 0001, 1000. First step occurs 4 cycles after the load.
3. mode_sel = 2, load → led follows 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. dir flips exactly at 1000 and at 0001.
4. mode_sel = 3, load → led = 1111, then 0000, then 1111 on successive ticks.
5. pause high for 10 cycles when cnt = 2 → led and cnt frozen, tick stays low. After release, the next tick comes 2 cycles later.
6. mode_load coincident with tick (cnt = 3) → no step occurs; led takes the load pattern and cnt = 0. Separately: assert sys_rst low mid-BOUNCE → led = 0001, mode = ROT_L immediately, without waiting for a clock edge.
